// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Issues two-operand requests to a registered ALU and checks what comes back.
//   Each accepted request is driven onto D0/D1/Command. Q and the range flags
//   are captured two edges after the accept and compared with an internal
//   reference. The result is buffered in a response FIFO. Saturating counters
//   track mismatches and the Low/Media/High classes.
//
// Ports
//   Clk, Reset            clock and asynchronous active-high reset (shared with ALU)
//   req_valid/req_ready   request handshake; req_d0/req_d1 operands, req_cmd op
//                         (0 add, 1 sub, 2 and, 3 or)
//   D0, D1, Command       registered operands/opcode to the ALU
//   Q, Low, Media, High   ALU result and range flags
//   rsp_valid/rsp_ready   response handshake; rsp_q, rsp_class (0 none, 1 Low,
//                         2 Media, 3 High), rsp_err (result/flags mismatch)
//   stats_clr             synchronous clear of the counters
//   err_count, low_count, media_count, high_count   saturating counters
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_d0,
  input  logic [31:0]      req_d1,
  input  logic [1:0]       req_cmd,
  output logic [31:0]      D0,
  output logic [31:0]      D1,
  output logic [1:0]       Command,
  input  logic [31:0]      Q,
  input  logic             Low,
  input  logic             Media,
  input  logic             High,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_q,
  output logic [1:0]       rsp_class,
  output logic             rsp_err,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] low_count,
  output logic [CNT_W-1:0] media_count,
  output logic [CNT_W-1:0] high_count
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = PTR_W + 2;

  function automatic logic signed [DATA_W-1:0] alu_ref(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [1:0]               cmd
  );
    case (cmd)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Returns {low, media, high}; all bounds exclusive.
  function automatic logic [2:0] range_flags(input logic signed [DATA_W-1:0] q);
    logic lo, md, hi;
    lo = q < -32'sd1000000000;
    md = (q > -32'sd10000000) && (q < 32'sd10000000);
    hi = q > 32'sd1000000000;
    return {lo, md, hi};
  endfunction

  // High wins over Media, Media over Low, when several flags are set.
  function automatic logic [1:0] flag_class(input logic [2:0] f);
    if (f[0])      return 2'd3;
    else if (f[1]) return 2'd2;
    else if (f[2]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  logic                     vld_p1, vld_p2;
  logic signed [DATA_W-1:0] exp_q_p1, exp_q_p2;
  logic [2:0]               exp_f_p1, exp_f_p2;
  logic signed [DATA_W-1:0] ref_q;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] q_mem   [DEPTH];
  logic [1:0]        cls_mem [DEPTH];
  logic              err_mem [DEPTH];

  logic       accept, push, pop;
  logic [2:0] obs_f;
  logic [1:0] cap_cls;
  logic       cap_err;

  // Credit counts every operation already committed to a FIFO slot, so the
  // FIFO cannot overflow even with rsp_ready held low.
  assign occ       = OCC_W'(fifo_cnt) + OCC_W'(vld_p1) + OCC_W'(vld_p2);
  assign req_ready = occ < OCC_W'(DEPTH);
  assign accept    = req_valid && req_ready;
  assign ref_q     = alu_ref(req_d0, req_d1, req_cmd);

  // ---- S1: issue to ALU, reference computed alongside ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1  <= 1'b0;
      D0      <= '0;
      D1      <= '0;
      Command <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        D0      <= req_d0;
        D1      <= req_d1;
        Command <= req_cmd;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      exp_q_p1 <= ref_q;
      exp_f_p1 <= range_flags(ref_q);
    end
  end

  // ---- S2: ALU registers operands; Q is valid during this cycle ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  always_ff @(posedge Clk) begin
    exp_q_p2 <= exp_q_p1;
    exp_f_p2 <= exp_f_p1;
  end

  // ---- Capture: check Q/flags, push into response FIFO ----
  assign obs_f   = {Low, Media, High};
  assign cap_cls = flag_class(obs_f);
  assign cap_err = (Q != $unsigned(exp_q_p2)) || (obs_f != exp_f_p2);
  assign push    = vld_p2;
  assign pop     = rsp_valid && rsp_ready;

  always_ff @(posedge Clk) begin
    if (push) begin
      q_mem[wr_ptr]   <= Q;
      cls_mem[wr_ptr] <= cap_cls;
      err_mem[wr_ptr] <= cap_err;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign rsp_valid = fifo_cnt != '0;
  assign rsp_q     = q_mem[rd_ptr];
  assign rsp_class = cls_mem[rd_ptr];
  assign rsp_err   = err_mem[rd_ptr];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_count   <= '0;
      low_count   <= '0;
      media_count <= '0;
      high_count  <= '0;
    end else if (stats_clr) begin
      err_count   <= '0;
      low_count   <= '0;
      media_count <= '0;
      high_count  <= '0;
    end else if (push) begin
      err_count   <= sat_inc(err_count,   cap_err);
      low_count   <= sat_inc(low_count,   cap_cls == 2'd1);
      media_count <= sat_inc(media_count, cap_cls == 2'd2);
      high_count  <= sat_inc(high_count,  cap_cls == 2'd3);
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered ALU model with fault injection,
// a queue-based response model, directed cases and randomized traffic.
module tb_alu_cmd_sequencer;

  localparam int TB_DEPTH = 4;
  localparam int TB_CNT_W = 4;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic [31:0] q;
    logic [1:0]  cls;
    logic        err;
  } rsp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [31:0] req_d0 = '0, req_d1 = '0;
  logic [1:0]  req_cmd = '0;
  logic [31:0] D0, D1;
  logic [1:0]  Command;
  logic [31:0] Q;
  logic Low, Media, High;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_q;
  logic [1:0]  rsp_class;
  logic rsp_err;
  logic stats_clr = 1'b0;
  logic [TB_CNT_W-1:0] err_count, low_count, media_count, high_count;

  int n_chk = 0, n_bad = 0;
  int n_acc = 0, n_pop = 0;
  int mode_req = 0;
  logic rand_rdy = 1'b0;
  rsp_t exp_q[$];
  int m_err = 0, m_low = 0, m_med = 0, m_high = 0;

  always #5 Clk = ~Clk;

  alu_cmd_sequencer #(.DEPTH(TB_DEPTH), .CNT_W(TB_CNT_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_d0(req_d0), .req_d1(req_d1), .req_cmd(req_cmd),
    .D0(D0), .D1(D1), .Command(Command),
    .Q(Q), .Low(Low), .Media(Media), .High(High),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_class(rsp_class), .rsp_err(rsp_err),
    .stats_clr(stats_clr),
    .err_count(err_count), .low_count(low_count),
    .media_count(media_count), .high_count(high_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] op_val(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    case (c)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic is_low(input logic [31:0] v);
    int s = v;
    return s < -1000000000;
  endfunction
  function automatic logic is_med(input logic [31:0] v);
    int s = v;
    return (s > -10000000) && (s < 10000000);
  endfunction
  function automatic logic is_high(input logic [31:0] v);
    int s = v;
    return s > 1000000000;
  endfunction

  function automatic logic [1:0] cls_of(input logic l, input logic m, input logic h);
    return h ? 2'd3 : m ? 2'd2 : l ? 2'd1 : 2'd0;
  endfunction

  // mode 0: healthy ALU, 1: Q bit0 flipped, 2: Low and High forced on
  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c, input int m);
    rsp_t r;
    logic [31:0] t;
    t = op_val(a, b, c);
    r.q   = (m == 1) ? (t ^ 32'd1) : t;
    r.cls = (m == 2) ? cls_of(1'b1, is_med(t), 1'b1) : cls_of(is_low(t), is_med(t), is_high(t));
    r.err = (m != 0);
    return r;
  endfunction

  // Registered ALU model; the fault mode travels with the operands.
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_c;
  int mode_s1, alu_mode;
  logic [31:0] alu_t;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      alu_a <= '0; alu_b <= '0; alu_c <= '0;
      mode_s1 <= 0; alu_mode <= 0;
    end else begin
      alu_a <= D0; alu_b <= D1; alu_c <= Command;
      mode_s1 <= (req_valid && req_ready) ? mode_req : 0;
      alu_mode <= mode_s1;
    end
  end

  always_comb begin
    alu_t = op_val(alu_a, alu_b, alu_c);
    Q     = (alu_mode == 1) ? (alu_t ^ 32'd1) : alu_t;
    Low   = is_low(alu_t)  || (alu_mode == 2);
    Media = is_med(alu_t);
    High  = is_high(alu_t) || (alu_mode == 2);
  end

  // Request-side model: record expected response and counter effect on accept.
  always @(posedge Clk) begin
    if (!Reset) begin
      if (stats_clr) begin
        m_err = 0; m_low = 0; m_med = 0; m_high = 0;
      end
      if (req_valid && req_ready) begin
        rsp_t r;
        r = model(req_d0, req_d1, req_cmd, mode_req);
        exp_q.push_back(r);
        n_acc++;
        if (!stats_clr) begin
          if (r.err && m_err < CMAX) m_err++;
          if (r.cls == 2'd1 && m_low < CMAX) m_low++;
          if (r.cls == 2'd2 && m_med < CMAX) m_med++;
          if (r.cls == 2'd3 && m_high < CMAX) m_high++;
        end
      end
    end
  end

  always @(posedge Reset) begin
    exp_q.delete();
    m_err = 0; m_low = 0; m_med = 0; m_high = 0;
  end

  // Response-side check, sampled mid-cycle.
  always @(negedge Clk) begin
    if (!Reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("stale_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_q", rsp_q, e.q);
        chk("rsp_class", {30'd0, rsp_class}, {30'd0, e.cls});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        n_pop++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c, input int m);
    int waitc = 0;
    logic got = 1'b0;
    req_d0 = a; req_d1 = b; req_cmd = c; mode_req = m; req_valid = 1'b1;
    while (!got && waitc < 100) begin
      @(negedge Clk); got = req_ready;
      @(posedge Clk); #1;
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      waitc++;
    end
    req_valid = 1'b0; mode_req = 0;
    if (!got) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // Single op on an idle pipe with rsp_ready=1; checks issue and latency.
  task automatic op_direct(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c, input int m,
                           input logic [31:0] eq, input logic [1:0] ecls, input logic eerr);
    send(a, b, c, m);
    chk("d0", D0, a);
    chk("d1", D1, b);
    chk("cmd", {30'd0, Command}, {30'd0, c});
    @(posedge Clk); #1;
    chk("lat_early", {31'd0, rsp_valid}, 32'd0);
    @(posedge Clk); #1;
    chk("lat_valid", {31'd0, rsp_valid}, 32'd1);
    chk("dir_q", rsp_q, eq);
    chk("dir_class", {30'd0, rsp_class}, {30'd0, ecls});
    chk("dir_err", {31'd0, rsp_err}, {31'd0, eerr});
    @(posedge Clk); #1;
  endtask

  task automatic chk_counts(input int e, input int l, input int m, input int h);
    chk("err_count", 32'(err_count), e);
    chk("low_count", 32'(low_count), l);
    chk("media_count", 32'(media_count), m);
    chk("high_count", 32'(high_count), h);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return $urandom();
      1: return 32'($urandom_range(0, 40)) - 32'd20;
      2: return 32'd10000000 + 32'($urandom_range(0, 4)) - 32'd2;
      3: return 32'd1000000000 + 32'($urandom_range(0, 4)) - 32'd2;
      4: return 32'd0 - 32'd1000000000 + 32'($urandom_range(0, 4)) - 32'd2;
      default: return 32'd0 - 32'd10000000 + 32'($urandom_range(0, 4)) - 32'd2;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int a0, p0;
    #13;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_d0", D0, 32'd0);
    chk("rst_cmd", {30'd0, Command}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk_counts(0, 0, 0, 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    op_direct(32'd5, 32'd7, 2'd0, 0, 32'd12, 2'd2, 1'b0);
    chk("media_after_add", 32'(media_count), 32'd1);
    op_direct(32'd0, 32'd1, 2'd1, 0, 32'hFFFF_FFFF, 2'd2, 1'b0);
    op_direct(32'h7FFF_FFFF, 32'd1, 2'd0, 0, 32'h8000_0000, 2'd1, 1'b0);
    op_direct(32'h4000_0000, 32'd0, 2'd3, 0, 32'h4000_0000, 2'd3, 1'b0);
    op_direct(32'd10000000, 32'd0, 2'd0, 0, 32'd10000000, 2'd0, 1'b0);
    op_direct(32'hC465_3600, 32'hFFFF_FFFF, 2'd2, 0, 32'hC465_3600, 2'd0, 1'b0);
    chk_counts(0, 1, 2, 1);

    // Fault injection
    op_direct(32'd5, 32'd7, 2'd0, 1, 32'd13, 2'd2, 1'b1);
    chk("err_after_f1", 32'(err_count), 32'd1);
    op_direct(32'd5, 32'd7, 2'd0, 2, 32'd12, 2'd3, 1'b1);
    chk_counts(2, 1, 3, 2);

    // stats_clr on the same edge as a capture
    send(32'd5, 32'd7, 2'd0, 1);
    @(posedge Clk); #1;
    stats_clr = 1'b1;
    @(posedge Clk); #1;
    stats_clr = 1'b0;
    chk_counts(0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;

    // Backpressure: held request with no response consumption
    rsp_ready = 1'b0;
    a0 = n_acc;
    req_d0 = 32'd3; req_d1 = 32'd4; req_cmd = 2'd0; req_valid = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    req_valid = 1'b0;
    chk("bp_accepts", n_acc - a0, 32'd4);
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    p0 = n_pop;
    rsp_ready = 1'b1;
    @(posedge Clk); #1;
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge Clk);
    #1;
    chk("bp_drain_pops", n_pop - p0, 32'd4);
    chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Reset mid-stream with three ops in flight
    rsp_ready = 1'b0;
    send(32'd1, 32'd1, 2'd0, 0);
    send(32'd2, 32'd2, 2'd0, 0);
    send(32'd3, 32'd3, 2'd0, 0);
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_d0", D0, 32'd0);
    chk("mid_rst_d1", D1, 32'd0);
    chk("mid_rst_cmd", {30'd0, Command}, 32'd0);
    chk_counts(0, 0, 0, 0);
    #1 Reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("post_rst_empty", {31'd0, rsp_valid}, 32'd0);
    op_direct(32'd5, 32'd7, 2'd0, 0, 32'd12, 2'd2, 1'b0);
    chk("post_rst_media", 32'(media_count), 32'd1);

    // Randomized traffic with random backpressure and occasional faults
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge Clk); #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        int m;
        m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
        send(pick(), pick(), 2'($urandom_range(0, 3)), m);
      end
    end
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge Clk); #1;
    end
    chk("final_drain", exp_q.size(), 32'd0);
    chk("final_valid", {31'd0, rsp_valid}, 32'd0);
    chk_counts(m_err, m_low, m_med, m_high);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator and checker for the registered two-operand ALU interface: Clk, Reset, D0, D1, Command, Q, Low, Media, High.
- Accepts operation requests over a valid/ready handshake and drives D0/D1/Command into the ALU.
- Captures Q and the range flags at the correct cycle and compares them against an internal reference model.
- Returns results through a buffered valid/ready response channel and keeps saturating statistics counters.

Parameters:
- DEPTH, 4, response FIFO entries; also the maximum number of operations in flight (power of 2, ≥2).
- CNT_W, 16, width of the statistics counters.

Ports:
- Clk  in  1  clock (shared with the ALU)
- Reset  in  1  asynchronous, active-high reset (shared with the ALU)
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready at posedge
- req_d0  in  32  operand A
- req_d1  in  32  operand B
- req_cmd  in  2  0 add, 1 sub, 2 and, 3 or
- D0  out  32  to ALU D0, registered
- D1  out  32  to ALU D1, registered
- Command  out  2  to ALU Command, registered
- Q  in  32  ALU result
- Low  in  1  ALU range flag
- Media  in  1  ALU range flag
- High  in  1  ALU range flag
- rsp_valid  out  1  response available (FIFO head)
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at posedge
- rsp_q  out  32  captured Q
- rsp_class  out  2  0 none, 1 Low, 2 Media, 3 High (from captured flags)
- rsp_err  out  1  captured Q or flags mismatch the model
- stats_clr  in  1  synchronous clear of all counters
- err_count  out  CNT_W  saturating mismatch count
- low_count  out  CNT_W  saturating Low-class count
- media_count  out  CNT_W  saturating Media-class count
- high_count  out  CNT_W  saturating High-class count

Behaviour:
- Reset (async, active-high):
  - D0, D1, Command = 0.
  - Pipeline valid bits cleared; FIFO emptied; rsp_valid = 0.
  - All counters = 0.
  - Reset mid-operation drops all in-flight operations and buffered responses. No response is produced for them.
- Issue stage (S1):
  - On accept, D0/D1/Command load req_d0/req_d1/req_cmd.
  - v1 is set, and the expected Q and expected flags are registered alongside.
  - Without an accept, D0/D1/Command hold their previous values and v1 = 0.
- ALU stage (S2):
  - v2 <= v1 and the expected values advance. The ALU registers D0/D1/Command on this edge, so Q is valid during the S2 cycle.
- Capture:
  - At the posedge ending the S2 cycle, when v2 = 1, push {Q, class, err} into the FIFO.
  - Latency: request accepted at edge N gives a FIFO push at edge N+2, so rsp_valid rises after edge N+2 (earliest consumption at edge N+3).
- Throughput: one operation per cycle sustained while rsp_ready = 1.
- Credit rule:
  - req_ready = (fifo_count + v1 + v2) < DEPTH, computed from registers only. It does not depend on req_valid or rsp_ready.
  - The FIFO can never overflow.
- Reference model:
  - Arithmetic is modulo 2^32: add = A+B, sub = A−B, and = A&B, or = A|B.
  - Flags use signed Q:
    - expLow = Q < −1_000_000_000
    - expMedia = −10_000_000 < Q < 10_000_000
    - expHigh = Q > 1_000_000_000
  - All bounds are exclusive.
- Error: err = 1 if Q ≠ expected, or {Low,Media,High} ≠ expected flags. Multiple flags asserted is therefore always an error.
- Class encoding:
  - High → 3, else Media → 2, else Low → 1, else 0.
  - On a multi-flag error the priority is High > Media > Low.
- FIFO:
  - Simultaneous push and pop on a full or empty FIFO is legal; count unchanged.
  - Pointers wrap modulo DEPTH.
  - rsp_q, rsp_class and rsp_err are stable while rsp_valid && !rsp_ready.
- Counters:
  - Update on each capture: err_count on err; the class counter for class 1/2/3.
  - Counters saturate at 2^CNT_W−1.
  - stats_clr has priority over a same-cycle increment (result 0).

Test Plan:
- Add: req 5 + 7 cmd 0 → D0=5, D1=7, Command=0 one cycle after accept; rsp_q=12, rsp_class=2, rsp_err=0 at edge N+2; media_count=1.
- Sub and wrap: 0 − 1 cmd 1 → rsp_q=0xFFFFFFFF, class 2. Then 0x7FFFFFFF + 1 cmd 0 → rsp_q=0x80000000, class 1, low_count=1. Then 0x40000000 | 0 cmd 3 → rsp_q=0x40000000, class 3, high_count=1.
- Boundaries:
  - 10_000_000 + 0 → class 0, no counter increments.
  - 0xC4653600 & 0xFFFFFFFF (−1_000_000_000) → class 0.
- Backpressure (DEPTH=4): rsp_ready=0 with req_valid held → exactly 4 accepts, req_ready=0 thereafter. Raise rsp_ready → in-order drain, one response per cycle, req_ready returns the cycle after the first pop.
- Fault injection: bench forces Q bit0 flipped, or Low and High both set → rsp_err=1, err_count increments by 1 per faulty op. Test with stats_clr asserted in the same cycle as an increment → count=0.
- Reset mid-stream: 3 ops in flight, Reset pulsed asynchronously between edges → immediately rsp_valid=0, D0/D1/Command=0, counters=0. No stale response appears after release; the next request completes normally with 2-cycle latency.
